led_event_stretcher: RTL and testbench

- Multi-channel pulse stretcher for board indicators.
- Turns single-cycle or level events (mouse clicks, cheat activation, link events) into LED pulses of exact, parameterised length.
- Supports optional retrigger, optional blink and per-channel saturating event counters.
- Sits between event-producing interfaces (e.g. mouse interface top) and board LEDs/debug displays; replaces ad-hoc per-signal counters.

---
 rtl/led_event_stretcher_pkg.sv | 15 +
 rtl/led_event_stretcher_stretch_channel.sv | 93 +++++++++
 rtl/led_event_stretcher.sv | 59 +++++
 tb/tb_led_event_stretcher.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_event_stretcher_pkg.sv
// Shared definitions for the LED event stretcher.
//   stretch_state_e : per-channel FSM state (idle / holding a pulse)
//   cnt_width()     : counter width able to hold 0..max_val, never below 1 bit
package led_event_stretcher_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stretch_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/led_event_stretcher_stretch_channel.sv
// One stretcher channel: hold FSM, blink phase generator and saturating
// event counter.
//   clk, rst  : clock, asynchronous active-high reset
//   trig      : accepted event for this channel (already edge-qualified)
//   clr_cnt   : synchronous clear of the event counter (wins over trig)
//   led       : LED drive, gated by the blink phase when blinking is enabled
//   active    : high for the whole hold window
//   evt_cnt   : saturating count of trig pulses
module stretch_channel
    import led_event_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 33554432,
    parameter int unsigned RETRIGGER   = 1,
    parameter int unsigned BLINK_HALF  = 0,
    parameter int unsigned EVT_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    input  logic                 clr_cnt,
    output logic                 led,
    output logic                 active,
    output logic [EVT_CNT_W-1:0] evt_cnt
);

    localparam int unsigned HOLD_W  = cnt_width(HOLD_CYCLES);
    localparam int unsigned BLINK_W = cnt_width(BLINK_HALF);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = (BLINK_HALF > 0) ? BLINK_W'(BLINK_HALF - 1) : '0;
    localparam logic BLINK_EN = (BLINK_HALF > 0);
    localparam logic RETRIG_EN = (RETRIGGER != 0);

    stretch_state_e     state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= HOLD_LOAD;
                        blink_cnt <= '0;
                        phase     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A retrigger on the final cycle reloads here, so the
                    // pulse extends without a gap.
                    if (trig && RETRIG_EN) begin
                        hold_cnt  <= HOLD_LOAD;
                        blink_cnt <= '0;
                        phase     <= 1'b1;
                    end else if (hold_cnt == '0) begin
                        state     <= ST_IDLE;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            phase     <= ~phase;
                        end else begin
                            blink_cnt <= blink_cnt + BLINK_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign active = (state == ST_HOLD);
    assign led    = active & (phase | ~BLINK_EN);

    // Counts every trig, including ones ignored for hold purposes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (clr_cnt) begin
            evt_cnt <= '0;
        end else if (trig && (evt_cnt != '1)) begin
            evt_cnt <= evt_cnt + EVT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_event_stretcher.sv
// Multi-channel pulse stretcher for board indicators.
//   clk, rst : clock, asynchronous active-high reset
//   evt      : per-channel event inputs, synchronous to clk
//   clr_cnt  : synchronous clear of all event counters
//   led      : LED drive per channel (blinks when BLINK_HALF > 0)
//   active   : per-channel hold window
//   evt_cnt  : flattened counters, channel i at [i*EVT_CNT_W +: EVT_CNT_W]
module led_event_stretcher
    import led_event_stretcher_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned HOLD_CYCLES = 33554432,
    parameter int unsigned RETRIGGER   = 1,
    parameter int unsigned EDGE_MODE   = 1,
    parameter int unsigned BLINK_HALF  = 0,
    parameter int unsigned EVT_CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             evt,
    input  logic                          clr_cnt,
    output logic [NUM_CH-1:0]             led,
    output logic [NUM_CH-1:0]             active,
    output logic [NUM_CH*EVT_CNT_W-1:0]   evt_cnt
);

    logic [NUM_CH-1:0] evt_q;
    logic [NUM_CH-1:0] trig;

    // Resets to all ones so an input already high at reset release is not
    // seen as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q <= '1;
        end else begin
            evt_q <= evt;
        end
    end

    assign trig = (EDGE_MODE != 0) ? (evt & ~evt_q) : evt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stretch_channel #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .RETRIGGER   (RETRIGGER),
            .BLINK_HALF  (BLINK_HALF),
            .EVT_CNT_W   (EVT_CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .trig    (trig[i]),
            .clr_cnt (clr_cnt),
            .led     (led[i]),
            .active  (active[i]),
            .evt_cnt (evt_cnt[i*EVT_CNT_W +: EVT_CNT_W])
        );
    end

endmodule

// File: tb/tb_led_event_stretcher.sv
// Self-checking bench for led_event_stretcher. Four instances share the
// stimulus: main (retrigger, edge mode), no-retrigger, level mode and blink.
// Edge n is the n-th rising clock edge after reset release; expectations are
// queued per edge and compared on the following falling edge.
`timescale 1ns/1ps
module tb_led_event_stretcher;

    localparam int unsigned S_ACT     = 0;
    localparam int unsigned S_LED     = 1;
    localparam int unsigned S_CNT0    = 2;
    localparam int unsigned S_CNT1    = 3;
    localparam int unsigned S_CNT2    = 4;
    localparam int unsigned S_NR_ACT  = 5;
    localparam int unsigned S_NR_CNT1 = 6;
    localparam int unsigned S_LV_ACT  = 7;
    localparam int unsigned S_LV_CNT2 = 8;
    localparam int unsigned S_BK_ACT  = 9;
    localparam int unsigned S_BK_LED  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [2:0]  evt = '0;
    logic [2:0]  led_m, act_m, led_nr, act_nr, led_lv, act_lv, led_bk, act_bk;
    logic [11:0] cnt_m, cnt_nr, cnt_lv, cnt_bk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned edge_n;

    typedef struct {
        int unsigned cyc;
        int unsigned sel;
        logic [7:0]  exp;
    } sb_entry_t;
    sb_entry_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    led_event_stretcher #(.NUM_CH(3), .HOLD_CYCLES(5), .RETRIGGER(1), .EDGE_MODE(1),
                          .BLINK_HALF(0), .EVT_CNT_W(4)) dut (
        .clk(clk), .rst(rst), .evt(evt), .clr_cnt(clr_cnt),
        .led(led_m), .active(act_m), .evt_cnt(cnt_m));

    led_event_stretcher #(.NUM_CH(3), .HOLD_CYCLES(5), .RETRIGGER(0), .EDGE_MODE(1),
                          .BLINK_HALF(0), .EVT_CNT_W(4)) dut_nr (
        .clk(clk), .rst(rst), .evt(evt), .clr_cnt(clr_cnt),
        .led(led_nr), .active(act_nr), .evt_cnt(cnt_nr));

    led_event_stretcher #(.NUM_CH(3), .HOLD_CYCLES(5), .RETRIGGER(1), .EDGE_MODE(0),
                          .BLINK_HALF(0), .EVT_CNT_W(4)) dut_lv (
        .clk(clk), .rst(rst), .evt(evt), .clr_cnt(clr_cnt),
        .led(led_lv), .active(act_lv), .evt_cnt(cnt_lv));

    led_event_stretcher #(.NUM_CH(3), .HOLD_CYCLES(8), .RETRIGGER(1), .EDGE_MODE(1),
                          .BLINK_HALF(2), .EVT_CNT_W(4)) dut_bk (
        .clk(clk), .rst(rst), .evt(evt), .clr_cnt(clr_cnt),
        .led(led_bk), .active(act_bk), .evt_cnt(cnt_bk));

    function automatic logic [7:0] actual(input int unsigned sel);
        case (sel)
            S_ACT:     return {5'b0, act_m};
            S_LED:     return {5'b0, led_m};
            S_CNT0:    return {4'b0, cnt_m[3:0]};
            S_CNT1:    return {4'b0, cnt_m[7:4]};
            S_CNT2:    return {4'b0, cnt_m[11:8]};
            S_NR_ACT:  return {5'b0, act_nr};
            S_NR_CNT1: return {4'b0, cnt_nr[7:4]};
            S_LV_ACT:  return {5'b0, act_lv};
            S_LV_CNT2: return {4'b0, cnt_lv[11:8]};
            S_BK_ACT:  return {5'b0, act_bk};
            S_BK_LED:  return {5'b0, led_bk};
            default:   return 8'hxx;
        endcase
    endfunction

    function automatic string sel_name(input int unsigned sel);
        case (sel)
            S_ACT:     return "active";
            S_LED:     return "led";
            S_CNT0:    return "cnt0";
            S_CNT1:    return "cnt1";
            S_CNT2:    return "cnt2";
            S_NR_ACT:  return "nr_active";
            S_NR_CNT1: return "nr_cnt1";
            S_LV_ACT:  return "lv_active";
            S_LV_CNT2: return "lv_cnt2";
            S_BK_ACT:  return "bk_active";
            S_BK_LED:  return "bk_led";
            default:   return "unknown";
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned cyc, input int unsigned sel, input logic [7:0] exp);
        sb.push_back('{cyc, sel, exp});
    endtask

    // Monitor: compares every expectation scheduled for the edge just taken.
    always @(negedge clk) begin : monitor
        sb_entry_t e;
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            e = sb.pop_front();
            if (e.cyc < edge_n) begin
                checks++;
                errors++;
                $display("FAIL %s@%0d: never sampled (now edge %0d)", sel_name(e.sel), e.cyc, edge_n);
            end else begin
                check($sformatf("%s@%0d", sel_name(e.sel), e.cyc), actual(e.sel), e.exp);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #1 rst = 1'b1;
        #1;
        check("reset_active", {5'b0, act_m}, 8'h00);
        check("reset_led",    {5'b0, led_m}, 8'h00);
        check("reset_cnt",    {4'b0, cnt_m[11:4]} | {4'b0, cnt_m[3:0]}, 8'h00);

        // 1: single pulse on ch0 at edge 10
        evt = '0;
        do_reset();
        for (int n = 9; n <= 16; n++) begin
            push(n, S_ACT, (n >= 10 && n <= 14) ? 8'h01 : 8'h00);
            push(n, S_LED, (n >= 10 && n <= 14) ? 8'h01 : 8'h00);
        end
        push(16, S_CNT0, 8'd1);
        push(16, S_CNT1, 8'd0);
        push(16, S_CNT2, 8'd0);
        for (int n = 1; n <= 16; n++) begin
            evt = (n == 10) ? 3'b001 : 3'b000;
            @(negedge clk);
        end
        drain();

        // 2a: ch1 triggers at edges 10 and 13
        evt = '0;
        do_reset();
        for (int n = 9; n <= 19; n++) begin
            push(n, S_ACT,    (n >= 10 && n <= 17) ? 8'h02 : 8'h00);
            push(n, S_NR_ACT, (n >= 10 && n <= 14) ? 8'h02 : 8'h00);
        end
        push(19, S_CNT1, 8'd2);
        push(19, S_NR_CNT1, 8'd2);
        for (int n = 1; n <= 19; n++) begin
            evt = (n == 10 || n == 13) ? 3'b010 : 3'b000;
            @(negedge clk);
        end
        drain();

        // 2b: retrigger exactly on the last hold cycle, then once more
        evt = '0;
        do_reset();
        for (int n = 9; n <= 23; n++) begin
            push(n, S_ACT, (n >= 10 && n <= 21) ? 8'h02 : 8'h00);
            push(n, S_NR_ACT, ((n >= 10 && n <= 14) || (n >= 17 && n <= 21)) ? 8'h02 : 8'h00);
        end
        push(23, S_CNT1, 8'd3);
        push(23, S_NR_CNT1, 8'd3);
        for (int n = 1; n <= 23; n++) begin
            evt = (n == 10 || n == 15 || n == 17) ? 3'b010 : 3'b000;
            @(negedge clk);
        end
        drain();

        // 3a: ch2 high through reset release must not trigger in edge mode
        evt = 3'b100;
        do_reset();
        for (int n = 1; n <= 36; n++)
            push(n, S_ACT, (n >= 30 && n <= 34) ? 8'h04 : 8'h00);
        push(36, S_CNT2, 8'd1);
        for (int n = 1; n <= 36; n++) begin
            evt = (n <= 20 || n >= 30) ? 3'b100 : 3'b000;
            @(negedge clk);
        end
        drain();

        // 3b: level mode, ch2 high for edges 10..12
        evt = '0;
        do_reset();
        for (int n = 9; n <= 18; n++)
            push(n, S_LV_ACT, (n >= 10 && n <= 16) ? 8'h04 : 8'h00);
        push(18, S_LV_CNT2, 8'd3);
        push(18, S_CNT2, 8'd1);
        for (int n = 1; n <= 18; n++) begin
            evt = (n >= 10 && n <= 12) ? 3'b100 : 3'b000;
            @(negedge clk);
        end
        drain();

        // 4: blink, hold 8, half period 2
        evt = '0;
        do_reset();
        for (int n = 9; n <= 19; n++) begin
            push(n, S_BK_ACT, (n >= 10 && n <= 17) ? 8'h01 : 8'h00);
            push(n, S_BK_LED, (n >= 10 && n <= 17 && ((n - 10) % 4) < 2) ? 8'h01 : 8'h00);
        end
        for (int n = 1; n <= 19; n++) begin
            evt = (n == 10) ? 3'b001 : 3'b000;
            @(negedge clk);
        end
        drain();

        // 5: counter saturation, clear beats a simultaneous trig
        evt = '0;
        do_reset();
        push(28, S_CNT0, 8'd14);
        push(30, S_CNT0, 8'd15);
        push(41, S_CNT0, 8'd15);
        push(43, S_CNT0, 8'd15);
        push(44, S_CNT0, 8'd0);
        push(46, S_CNT0, 8'd1);
        for (int n = 1; n <= 46; n++) begin
            evt = (((n % 2) == 0 && n <= 40) || n == 44 || n == 46) ? 3'b001 : 3'b000;
            clr_cnt = (n == 44);
            @(negedge clk);
        end
        clr_cnt = 1'b0;
        drain();

        // 6: asynchronous reset in the middle of a pulse
        evt = '0;
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            evt = (n == 10) ? 3'b001 : 3'b000;
            @(negedge clk);
        end
        check("pre_reset_active", {5'b0, act_m}, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("async_reset_active", {5'b0, act_m}, 8'h00);
        check("async_reset_led",    {5'b0, led_m}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 15; n++)
            push(n, S_ACT, 8'h00);
        push(15, S_CNT0, 8'd0);
        for (int n = 1; n <= 15; n++) begin
            evt = 3'b000;
            @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
